xor_rr_arbiter: RTL

Shares one 4-bit XOR datapath (one xor_4bit instance) between N_REQ requesters using a round-robin arbiter.
- Each requester presents two 4-bit operands and a level request.
- The block latches the winner's operands and computes x XOR y through the shared unit.
- It returns a registered result, with a one-cycle grant pulse to the served requester.
- It sits between the requester clients and the xor_4bit datapath; clients never instantiate XOR logic themselves.

---
 rtl/xor_rr_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/xor_rr_arbiter.sv
// xor_rr_arbiter: round-robin arbiter that shares one 4-bit XOR unit among
// N_REQ requesters. The winner's operands are latched and XORed in EXEC. The
// registered result is then returned with a one-cycle gnt/z_valid pulse.
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   req      : level request per requester, held until its gnt bit pulses
//   x_bus    : operand x, requester i on [4i+3:4i]
//   y_bus    : operand y, requester i on [4i+3:4i]
//   gnt      : one-hot pulse marking the requester whose result is on z_out
//   z_out    : registered XOR result, held until the next completion
//   z_valid  : one-cycle pulse coincident with gnt
//   gnt_id   : binary index of the served requester (valid with z_valid)
//   busy     : high while in EXEC
//   ops_cnt  : completed operations, wraps at 256
//
// state  | meaning
// IDLE   | arbitrate among req & ~gnt, latch winner operands on a hit
// EXEC   | shared XOR evaluates latched operands, result registered on exit
module xor_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] x_bus,
  input  logic [4*N_REQ-1:0] y_bus,
  output logic [N_REQ-1:0]   gnt,
  output logic [3:0]         z_out,
  output logic               z_valid,
  output logic [IDW-1:0]     gnt_id,
  output logic               busy,
  output logic [7:0]         ops_cnt
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  logic [0:0]       state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id_r;
  logic [3:0]       op_x;
  logic [3:0]       op_y;
  logic [3:0]       xor_res;
  logic [N_REQ-1:0] eff;
  logic             found;
  logic [IDW-1:0]   win_id;
  logic [3:0]       sel_x;
  logic [3:0]       sel_y;
  logic [IDW-1:0]   ptr_next;

  // A requester still showing its gnt pulse has already been served; its
  // held req must not win again this cycle.
  assign eff = req & ~gnt;

  // Scan ptr, ptr+1, ... modulo N_REQ; the first set bit wins.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && eff[idx]) begin
        found  = 1'b1;
        win_id = IDW'(idx);
      end
    end
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_id == IDW'(i)) begin
        sel_x = x_bus[4*i +: 4];
        sel_y = y_bus[4*i +: 4];
      end
    end
  end

  assign ptr_next = (id_r == IDW'(N_REQ - 1)) ? '0 : id_r + 1'b1;

  xor_4bit u_xor (
    .a (op_x),
    .b (op_y),
    .y (xor_res)
  );

  assign busy = (state == S_EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ptr     <= '0;
      id_r    <= '0;
      op_x    <= '0;
      op_y    <= '0;
      gnt     <= '0;
      z_out   <= '0;
      z_valid <= 1'b0;
      gnt_id  <= '0;
      ops_cnt <= '0;
    end else begin
      gnt     <= '0;
      z_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            op_x  <= sel_x;
            op_y  <= sel_y;
            id_r  <= win_id;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          z_out   <= xor_res;
          gnt     <= N_REQ'(1) << id_r;
          gnt_id  <= id_r;
          z_valid <= 1'b1;
          ops_cnt <= ops_cnt + 8'd1;
          ptr     <= ptr_next;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// xor_4bit: the shared combinational datapath.
//   a, b : 4-bit operands
//   y    : a ^ b
module xor_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);
  assign y = a ^ b;
endmodule
